// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: byte-writable RAM, one-cycle read latency.
// Optional MMIO window (LED, TIMER, COMPARE, STATUS, timer_irq) built when MMIO_EN is defined.
module data_sram_resp #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        timer_irq
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              acc_wr;
  logic              acc_rd;
  logic              is_mmio;
  logic [31:0]       mmio_rdata;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;
  logic              unused_addr;

  assign word_idx    = data_sram_addr[ADDR_W+1:2];
  assign acc_wr      = data_sram_en && (data_sram_wen != 4'b0000);
  assign acc_rd      = data_sram_en && (data_sram_wen == 4'b0000);
  assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // RAM contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && acc_wr && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (acc_rd) begin
      rdata_d = is_mmio ? mmio_rdata : mem[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;

`ifdef MMIO_EN
  localparam logic [13:0] OFF_LED    = 14'h0;
  localparam logic [13:0] OFF_TIMER  = 14'h1;
  localparam logic [13:0] OFF_CMP    = 14'h2;
  localparam logic [13:0] OFF_STATUS = 14'h3;

  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic [13:0] reg_sel;
  logic        mmio_wr;
  logic        match;
  logic        irq_clr;

  assign is_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign reg_sel = data_sram_addr[15:2];
  assign mmio_wr = acc_wr && is_mmio;
  // Match looks at pre-edge TIMER/COMPARE, so same-cycle writes to either do not affect it.
  assign match   = (timer_q == compare_q) && (compare_q != 32'd0);
  assign irq_clr = mmio_wr && (reg_sel == OFF_STATUS) && data_sram_wen[0] && data_sram_wdata[0];

  always_comb begin
    case (reg_sel)
      OFF_LED:    mmio_rdata = {16'b0, led_q};
      OFF_TIMER:  mmio_rdata = timer_q;
      OFF_CMP:    mmio_rdata = compare_q;
      OFF_STATUS: mmio_rdata = {31'b0, pend_q};
      default:    mmio_rdata = '0;
    endcase

    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    compare_d = compare_q;
    if (mmio_wr) begin
      case (reg_sel)
        OFF_LED: led_d = {data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8],
                          data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0]};
        OFF_TIMER: timer_d = merge_lanes(timer_q, data_sram_wdata, data_sram_wen);
        OFF_CMP:   compare_d = merge_lanes(compare_q, data_sram_wdata, data_sram_wen);
        default:   ;
      endcase
    end
    pend_d = match || (pend_q && !irq_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      timer_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      led_q     <= led_d;
      timer_q   <= timer_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign led       = led_q;
  assign timer_irq = pend_q;
`else
  assign is_mmio    = 1'b0;
  assign mmio_rdata = '0;
  assign led        = '0;
  assign timer_irq  = 1'b0;
`endif

endmodule
